// File: rtl/low_priority_request_serializer_pkg.sv
// low_priority_request_serializer_pkg: shared state encoding and default sizing
// for the request serializer.
package low_priority_request_serializer_pkg;
    typedef enum logic {IDLE, SERVE} ser_state_t;
    localparam int NUM_REQ_DEFAULT = 8;
endpackage

// File: rtl/low_priority_request_serializer_lowest_set_index.sv
// lowest_set_index: combinational lowest-set-bit finder returning the bit index,
// an any-set flag and the isolated one-hot bit.
module lowest_set_index
    import low_priority_request_serializer_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0]         vector,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       any_set,
    output logic [NUM_REQ-1:0]         one_hot
);
    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (vector[i]) index = i[IDX_W-1:0];
        any_set = |vector;
        // two's-complement trick isolates the lowest set bit
        one_hot = vector & (~vector + NUM_REQ'(1));
    end
endmodule

// File: rtl/low_priority_request_serializer.sv
// low_priority_request_serializer: captures a request vector and drains the index
// of every set bit, lowest first, over a valid/ready handshake.
module low_priority_request_serializer
    import low_priority_request_serializer_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic                       Clock_In,
    input  logic                       Reset_N_In,
    input  logic [NUM_REQ-1:0]         Req_Vector_In,
    input  logic                       Req_Valid_In,
    output logic                       Req_Ready_Out,
    output logic [$clog2(NUM_REQ)-1:0] Index_Out,
    output logic                       Index_Valid_Out,
    input  logic                       Index_Ready_In,
    output logic                       Last_Out,
    output logic                       Zero_Drop_Out
);
    localparam int IDX_W = $clog2(NUM_REQ);

    ser_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d, one_hot;
    logic [IDX_W-1:0]   index;
    logic               alive_q, zero_drop_q, zero_drop_d;
    logic               any_set, last, capture, take;

    lowest_set_index #(.NUM_REQ(NUM_REQ)) u_lowest_set_index (
        .vector  (pending_q),
        .index   (index),
        .any_set (any_set),
        .one_hot (one_hot)
    );

    always_comb begin
        last        = any_set && ((pending_q & ~one_hot) == '0);
        capture     = state_q == IDLE && alive_q && Req_Valid_In;
        take        = state_q == SERVE && Index_Ready_In;
        zero_drop_d = capture && Req_Vector_In == '0;
        state_d     = state_q;
        pending_d   = pending_q;
        if (capture && Req_Vector_In != '0) begin
            state_d   = SERVE;
            pending_d = Req_Vector_In;
        end
        if (take) begin
            pending_d = pending_q & ~one_hot;
            state_d   = last ? IDLE : SERVE;
        end
    end

    // alive_q holds ready low until the first edge after reset release
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
            alive_q     <= 1'b1;
        end
    end

    assign Req_Ready_Out   = state_q == IDLE && alive_q;
    assign Index_Valid_Out = state_q == SERVE;
    assign Index_Out       = index;
    assign Last_Out        = last;
    assign Zero_Drop_Out   = zero_drop_q;
endmodule
